part_bus_demux_rx: RTL
======================

Name: part_bus_demux_rx

Overview:
- Receive end of the time-multiplexed nibble bus driven by the quad 2:1 tri-state selector parts.
- The driver places slot N of a word on BUS while SEL=N, and marks valid phases with its active-low enable.
- This block samples each valid phase and reassembles full words in slot order.
- Completed words are buffered in a small FIFO and presented on a valid/ready interface to the consuming datapath.

Parameters:
- NIBW, 4, width of the shared bus (one 258 package = 4 lines).
- SLOTS, 2, phases per word; SELW = max(1, clog2(SLOTS)).
- DEPTH, 2, output FIFO depth in words (power of two, >=2).

Ports:
- CLK  input  1  sole clock, all state on rising edge.
- RESET  input  1  asynchronous, active-high; clears all state.
- BUS  input  NIBW  sampled bus lines.
- BUS_SEL  input  SELW  slot index the driver is presenting.
- BUS_ENB_N  input  1  driver enable; 0 = BUS valid this cycle, 1 = bus floating, ignore.
- WORD  output  NIBW*SLOTS  FIFO head; slot 0 in the LSBs.
- WORD_VALID  output  1  FIFO not empty.
- WORD_RDY  input  1  consumer accepts head when WORD_VALID & WORD_RDY.
- ERR_SEQ  output  1  sticky slot-order error.
- OVERRUN  output  1  sticky: a completed word was dropped because the FIFO was full.
- CLR_ERR  input  1  synchronous clear of sticky flags.

Behaviour:
- Reset values:
  - WORD=0, WORD_VALID=0, ERR_SEQ=0, OVERRUN=0.
  - FSM=IDLE, slot count=0, FIFO empty.
  - RESET asserted mid-word discards the partial word and all buffered words.
- Sampling occurs only on rising CLK with BUS_ENB_N=0. Cycles with BUS_ENB_N=1 hold all assembly state; gaps of any length are allowed between phases.
- FSM IDLE:
  - Sample with BUS_SEL=0: store slot 0, cnt=1, go to ASM.
  - If SLOTS=1, the word completes immediately.
  - Sample with BUS_SEL!=0: set ERR_SEQ, stay IDLE, discard the nibble.
- FSM ASM:
  - Sample with BUS_SEL==cnt: store the slot, cnt+1.
  - If cnt was SLOTS-1: word complete, push to FIFO, cnt=0, go to IDLE.
  - Sample with BUS_SEL==0 (restart): set ERR_SEQ, discard the partial word, take this nibble as the new slot 0, cnt=1, stay in ASM.
  - Any other BUS_SEL: set ERR_SEQ, discard the partial word, go to IDLE.
- Latency: last-slot sample at edge k gives WORD/WORD_VALID updated after edge k (visible in cycle k+1) when the FIFO was empty. There is no combinational path from BUS to WORD.
- FIFO:
  - Pop when WORD_VALID & WORD_RDY. WORD shows the next entry (or holds its last value if the FIFO is now empty) after the edge.
  - Push when full without a same-cycle pop: the new word is dropped, OVERRUN is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, no overrun.
  - Push and pop in the same cycle while empty: the push lands and WORD_VALID=1 next cycle. The pop is ignored because WORD_VALID was 0.
  - Read and write pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1 state count.
- Sticky flags:
  - CLR_ERR clears ERR_SEQ and OVERRUN.
  - If a new error occurs in the same cycle as CLR_ERR, the set wins.
- BUS_SEL values >= SLOTS are treated as any other out-of-order value.

Optional Feature:
- Macro PART_BUS_RX_PARITY_EN.
- When defined, the block adds:
  - Input BUS_PAR (1 bit): odd parity over BUS, sampled with BUS.
  - Output PAR_ERR (1 bit): sticky, cleared by CLR_ERR.
- A parity failure on any accepted phase sets PAR_ERR and marks the word in assembly bad. A bad word is discarded at completion: no push, no OVERRUN. The mark clears at IDLE or on restart.
- When undefined, neither port exists and all words are pushed.

Test Plan:
- SLOTS=2, WORD_RDY=1:
  - Stimulus: ENB_N=0 with SEL=0 BUS=0x5, then SEL=1 BUS=0xA.
  - Response: WORD=0xA5 and WORD_VALID=1 for exactly 1 cycle, starting the cycle after the second sample.
- Same word with 3 ENB_N=1 gap cycles between phases, during which BUS toggles garbage -> WORD=0xA5, ERR_SEQ=0.
- Phase order SEL=0 (0x1), SEL=0 (0x2), SEL=1 (0x3):
  - ERR_SEQ=1.
  - Exactly one word 0x32 emitted.
  - CLR_ERR then gives ERR_SEQ=0.
- Phase SEL=1 while IDLE -> ERR_SEQ=1, no word emitted, next good pair 0x0/0xF gives WORD=0xF0.
- DEPTH=2, WORD_RDY=0:
  - Stimulus: send words 0x11, 0x22, 0x33.
  - Response: OVERRUN=1. Raising WORD_RDY then yields 0x11, 0x22 in order, then WORD_VALID=0.
  - Repeat with full FIFO and WORD_RDY=1 on the completing cycle: no OVERRUN.
- RESET pulsed after slot 0 only, then a full pair 0x7/0x8 -> single word 0x87, all flags 0.
- With PART_BUS_RX_PARITY_EN: bad BUS_PAR on slot 1 -> PAR_ERR=1, no word emitted.

Source files
------------

// File: rtl/part_bus_demux_rx_if.sv
// Receive-side bundle for the nibble-mux bus plus the word valid/ready port.
// Optional parity lines exist only when PART_BUS_RX_PARITY_EN is defined.
interface part_bus_demux_rx_if #(
   parameter int NIBW  = 4,
   parameter int SLOTS = 2
);
   localparam int SELW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   logic [NIBW-1:0]       BUS;
   logic [SELW-1:0]       BUS_SEL;
   logic                  BUS_ENB_N;
   // WORD is accepted on a rising edge where WORD_VALID & WORD_RDY; WORD_VALID
   // never depends on WORD_RDY, and WORD/WORD_VALID hold until accepted.
   logic [NIBW*SLOTS-1:0] WORD;
   logic                  WORD_VALID;
   logic                  WORD_RDY;
   logic                  ERR_SEQ;
   logic                  OVERRUN;
   logic                  CLR_ERR;
`ifdef PART_BUS_RX_PARITY_EN
   logic                  BUS_PAR;
   logic                  PAR_ERR;

   modport master (output BUS, BUS_SEL, BUS_ENB_N, BUS_PAR, WORD_RDY, CLR_ERR,
                   input  WORD, WORD_VALID, ERR_SEQ, OVERRUN, PAR_ERR);
   modport slave  (input  BUS, BUS_SEL, BUS_ENB_N, BUS_PAR, WORD_RDY, CLR_ERR,
                   output WORD, WORD_VALID, ERR_SEQ, OVERRUN, PAR_ERR);
`else
   modport master (output BUS, BUS_SEL, BUS_ENB_N, WORD_RDY, CLR_ERR,
                   input  WORD, WORD_VALID, ERR_SEQ, OVERRUN);
   modport slave  (input  BUS, BUS_SEL, BUS_ENB_N, WORD_RDY, CLR_ERR,
                   output WORD, WORD_VALID, ERR_SEQ, OVERRUN);
`endif
endinterface

// File: rtl/part_bus_demux_rx.sv
// Reassembles slot-multiplexed nibbles into words and queues them in a small FIFO.
// Optional per-phase odd parity checking under PART_BUS_RX_PARITY_EN.
module part_bus_demux_rx #(
   parameter int NIBW  = 4,
   parameter int SLOTS = 2,
   parameter int DEPTH = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   part_bus_demux_rx_if.slave bus_if,
   output logic              dbg_state_o
);
   localparam int SELW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int WW   = NIBW * SLOTS;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;

   typedef enum logic {IDLE = 1'b0, ASM = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [SELW-1:0] cnt_q, cnt_d;
   logic [WW-1:0]   asm_q, asm_d;
   logic            seq_err, done, slot_ok, push_req;

   logic [WW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   count_q;
   logic [WW-1:0]   last_q;
   logic            pop, full, push, ovr_set;
   logic            err_seq_q, overrun_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
      end
   end

   // Disabled bus cycles leave every piece of assembly state untouched.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      seq_err = 1'b0;
      done    = 1'b0;
      slot_ok = 1'b0;
      if (!bus_if.BUS_ENB_N) begin
         unique case (state_q)
            IDLE: begin
               if (bus_if.BUS_SEL == '0) begin
                  asm_d[NIBW-1:0] = bus_if.BUS;
                  slot_ok         = 1'b1;
                  if (SLOTS == 1) begin
                     done = 1'b1;
                  end else begin
                     cnt_d   = SELW'(1);
                     state_d = ASM;
                  end
               end else begin
                  seq_err = 1'b1;
               end
            end
            ASM: begin
               if (bus_if.BUS_SEL == cnt_q) begin
                  asm_d[int'(cnt_q)*NIBW +: NIBW] = bus_if.BUS;
                  slot_ok = 1'b1;
                  if (cnt_q == SELW'(SLOTS - 1)) begin
                     done    = 1'b1;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + SELW'(1);
                  end
               end else if (bus_if.BUS_SEL == '0) begin
                  // Restart: this nibble begins a fresh word.
                  asm_d[NIBW-1:0] = bus_if.BUS;
                  slot_ok = 1'b1;
                  seq_err = 1'b1;
                  cnt_d   = SELW'(1);
               end else begin
                  seq_err = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef PART_BUS_RX_PARITY_EN
   logic bad_q, bad_d, par_fail, fresh, word_bad, par_err_q;

   // fresh marks a slot-0 accept, from IDLE or via restart.
   always_comb begin
      par_fail = slot_ok && !(^{bus_if.BUS, bus_if.BUS_PAR});
      fresh    = (state_q == IDLE) || (bus_if.BUS_SEL != cnt_q);
      word_bad = fresh ? par_fail : (bad_q | par_fail);
      bad_d    = bad_q;
      if (slot_ok) bad_d = word_bad;
      if ((seq_err && !slot_ok) || done) bad_d = 1'b0;
      push_req = done && !word_bad;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bad_q     <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         bad_q     <= bad_d;
         par_err_q <= par_fail | (par_err_q & ~bus_if.CLR_ERR);
      end
   end

   assign bus_if.PAR_ERR = par_err_q;
`else
   assign push_req = done;
`endif

   assign pop     = (count_q != '0) && bus_if.WORD_RDY;
   assign full    = (count_q == CW'(DEPTH));
   assign push    = push_req && (!full || pop);
   assign ovr_set = push_req && full && !pop;

   // last_q keeps the most recently consumed word visible once the FIFO drains.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         count_q   <= '0;
         last_q    <= '0;
         err_seq_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= asm_d;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop) begin
            last_q <= mem_q[rd_q];
            rd_q   <= rd_q + AW'(1);
         end
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
         err_seq_q <= seq_err | (err_seq_q & ~bus_if.CLR_ERR);
         overrun_q <= ovr_set | (overrun_q & ~bus_if.CLR_ERR);
      end
   end

   assign bus_if.WORD_VALID = (count_q != '0);
   assign bus_if.WORD       = (count_q != '0) ? mem_q[rd_q] : last_q;
   assign bus_if.ERR_SEQ    = err_seq_q;
   assign bus_if.OVERRUN    = overrun_q;
   assign dbg_state_o       = state_q;
endmodule
